// File: rtl/utpu_pkg.sv
// Shared definitions for the weight-stationary systolic array.
//
// Contents:
//   state_e    - control FSM states (IDLE, COMPUTE, DRAIN)
//   DEF_*      - default array size and datapath widths
//   cnt_width  - width of a counter/pointer that must hold values 0..n-1
//
// Optional feature macro used by the files that import this package:
//   MAC_SATURATE_EN - PE additions saturate instead of wrapping.
package utpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    localparam int DEF_ROWS      = 4;
    localparam int DEF_COLS      = 4;
    localparam int DEF_COMPUTE_W = 4;
    localparam int DEF_ACC_W     = 16;

    // A single-entry range still needs one bit of storage.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element of the systolic array.
//
// Holds a stationary weight, forwards the activation to the right and the
// partial sum downward. Activation and partial-sum registers only update
// when the incoming valid is set, so bubbles leave the last result in place.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   w_load    - capture w_in into the weight register
//   w_in      - weight value (signed, COMPUTE_DATA_WIDTH)
//   act_in    - activation from the left neighbour / skew line
//   vld_in    - activation valid travelling with act_in
//   psum_in   - partial sum from the PE above (zero for the top row)
//   act_out   - registered activation to the right neighbour
//   vld_out   - registered valid to the right neighbour
//   psum_out  - registered partial sum to the PE below
//
// Macro: MAC_SATURATE_EN selects saturating addition; default wraps.
module mac_pe
    import utpu_pkg::*;
#(
    parameter int COMPUTE_DATA_WIDTH     = DEF_COMPUTE_W,
    parameter int ACCUMULATOR_DATA_WIDTH = DEF_ACC_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              w_load,
    input  logic [COMPUTE_DATA_WIDTH-1:0]     w_in,
    input  logic [COMPUTE_DATA_WIDTH-1:0]     act_in,
    input  logic                              vld_in,
    input  logic [ACCUMULATOR_DATA_WIDTH-1:0] psum_in,
    output logic [COMPUTE_DATA_WIDTH-1:0]     act_out,
    output logic                              vld_out,
    output logic [ACCUMULATOR_DATA_WIDTH-1:0] psum_out
);

    localparam int CW = COMPUTE_DATA_WIDTH;
    localparam int AW = ACCUMULATOR_DATA_WIDTH;

`ifdef MAC_SATURATE_EN
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
`endif

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [AW-1:0] mul_ext(input logic signed [CW-1:0] a,
                                                     input logic signed [CW-1:0] w);
        logic signed [2*CW-1:0] prod;
        prod = (2*CW)'(a) * (2*CW)'(w);
        return AW'(prod);
    endfunction

    function automatic logic signed [AW-1:0] mac_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
`ifdef MAC_SATURATE_EN
        logic signed [AW:0] wide;
        wide = {a[AW-1], a} + {b[AW-1], b};
        // Overflow shows up as the two top bits disagreeing.
        if (wide[AW] != wide[AW-1]) begin
            return wide[AW] ? ACC_MIN : ACC_MAX;
        end
        return wide[AW-1:0];
`else
        return a + b;
`endif
    endfunction

    logic [CW-1:0] wgt_q, wgt_d;
    logic [CW-1:0] act_q, act_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] psum_q, psum_d;

    always_comb begin
        wgt_d  = w_load ? w_in : wgt_q;
        vld_d  = vld_in;
        act_d  = act_q;
        psum_d = psum_q;
        if (vld_in) begin
            act_d  = act_in;
            psum_d = mac_add(psum_in, mul_ext(act_in, wgt_q));
        end
    end

    // ---- PE register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wgt_q  <= '0;
            act_q  <= '0;
            vld_q  <= 1'b0;
            psum_q <= '0;
        end else begin
            wgt_q  <= wgt_d;
            act_q  <= act_d;
            vld_q  <= vld_d;
            psum_q <= psum_d;
        end
    end

    assign act_out  = act_q;
    assign vld_out  = vld_q;
    assign psum_out = psum_q;

endmodule

// File: rtl/systolic_array.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine.
//
// Weights are loaded one row per cycle while idle. A pass streams unskewed
// activation vectors in; row r is delayed r cycles before entering the grid
// and column c is delayed COLS-1-c cycles on the way out so each result
// vector appears aligned, ROWS+COLS-1 cycles after its input was accepted.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load_en      - write weight_in to the current weight row (IDLE only)
//   weight_in    - one weight row, COLS signed elements
//   start        - begin a pass (needs a complete weight set)
//   in_valid     - activation vector valid
//   in_last      - marks the final vector of the pass
//   in           - activation vector, ROWS signed elements
//   in_ready     - high while accepting vectors (COMPUTE)
//   out_valid    - result vector valid (no backpressure)
//   accumulator  - result vector, COLS signed elements; holds between results
//   busy         - FSM not idle
//   done         - one-cycle pulse with the last result of a pass
//
// Macro: MAC_SATURATE_EN makes every PE addition saturate (default wraps).
module systolic_array
    import utpu_pkg::*;
#(
    parameter int ROWS                   = DEF_ROWS,
    parameter int COLS                   = DEF_COLS,
    parameter int COMPUTE_DATA_WIDTH     = DEF_COMPUTE_W,
    parameter int ACCUMULATOR_DATA_WIDTH = DEF_ACC_W
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load_en,
    input  logic [COLS-1:0][COMPUTE_DATA_WIDTH-1:0]     weight_in,
    input  logic                                        start,
    input  logic                                        in_valid,
    input  logic                                        in_last,
    input  logic [ROWS-1:0][COMPUTE_DATA_WIDTH-1:0]     in,
    output logic                                        in_ready,
    output logic                                        out_valid,
    output logic [COLS-1:0][ACCUMULATOR_DATA_WIDTH-1:0] accumulator,
    output logic                                        busy,
    output logic                                        done
);

    localparam int CW     = COMPUTE_DATA_WIDTH;
    localparam int AW     = ACCUMULATOR_DATA_WIDTH;
    localparam int LAT    = ROWS + COLS - 1;
    localparam int WPTR_W = cnt_width(ROWS);
    localparam int CNT_W  = cnt_width(LAT);

    // ------------------------------------------------------------------
    // Control FSM, weight row pointer and drain counter
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [WPTR_W-1:0] wptr_q, wptr_d;
    logic              loaded_q, loaded_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_ok;
    logic              accept;
    logic [ROWS-1:0]   row_load;

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        loaded_d = loaded_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        done     = 1'b0;
        load_ok  = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                load_ok = load_en;
                if (load_en) begin
                    // A load in the same cycle as start wins; start is dropped.
                    if (wptr_q == WPTR_W'(ROWS - 1)) begin
                        wptr_d   = '0;
                        loaded_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + WPTR_W'(1);
                    end
                end else if (start && loaded_q) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // The last drain cycle is exactly when the final result is out.
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_load = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_load[r] = load_ok && (wptr_q == WPTR_W'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            loaded_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Input skew: row r passes through r registers before the grid
    // ------------------------------------------------------------------
    logic [CW-1:0] row_act [ROWS];
    logic [ROWS-1:0] row_vld;

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign row_act[r] = in[r];
            assign row_vld[r] = accept;
        end else begin : g_delay
            logic [r-1:0][CW-1:0] sk_act_q, sk_act_d;
            logic [r-1:0]         sk_vld_q, sk_vld_d;

            always_comb begin
                sk_act_d[0] = in[r];
                sk_vld_d[0] = accept;
                for (int k = 1; k < r; k++) begin
                    sk_act_d[k] = sk_act_q[k-1];
                    sk_vld_d[k] = sk_vld_q[k-1];
                end
            end

            // ---- skew register stages ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    sk_act_q <= '0;
                    sk_vld_q <= '0;
                end else begin
                    sk_act_q <= sk_act_d;
                    sk_vld_q <= sk_vld_d;
                end
            end

            assign row_act[r] = sk_act_q[r-1];
            assign row_vld[r] = sk_vld_q[r-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid: activations move right, partial sums move down
    // ------------------------------------------------------------------
    logic [CW-1:0] act_link  [ROWS][COLS+1];
    logic          vld_link  [ROWS][COLS+1];
    logic [AW-1:0] psum_link [ROWS+1][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign act_link[r][0] = row_act[r];
        assign vld_link[r][0] = row_vld[r];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_pe #(
                .COMPUTE_DATA_WIDTH    (CW),
                .ACCUMULATOR_DATA_WIDTH(AW)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .w_load  (row_load[r]),
                .w_in    (weight_in[c]),
                .act_in  (act_link[r][c]),
                .vld_in  (vld_link[r][c]),
                .psum_in (psum_link[r][c]),
                .act_out (act_link[r][c+1]),
                .vld_out (vld_link[r][c+1]),
                .psum_out(psum_link[r+1][c])
            );
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top
        assign psum_link[0][c] = '0;
    end

    // Right-edge activations leave the grid unused.
    logic unused_edge;
    always_comb begin
        unused_edge = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            unused_edge = unused_edge ^ (^act_link[r][COLS]) ^ vld_link[r][COLS];
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column c waits COLS-1-c cycles. Stages only load on
    // valid data, so the final stage doubles as the holding result register.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        if (c == COLS - 1) begin : g_direct
            assign accumulator[c] = psum_link[ROWS][c];
        end else begin : g_delay
            localparam int D = COLS - 1 - c;
            logic [D-1:0][AW-1:0] dk_q, dk_d;
            logic [D-1:0]         dv_q, dv_d;
            logic                 unused_dv;

            always_comb begin
                dk_d[0] = vld_link[ROWS-1][c+1] ? psum_link[ROWS][c] : dk_q[0];
                dv_d[0] = vld_link[ROWS-1][c+1];
                for (int k = 1; k < D; k++) begin
                    dk_d[k] = dv_q[k-1] ? dk_q[k-1] : dk_q[k];
                    dv_d[k] = dv_q[k-1];
                end
            end

            // ---- deskew register stages ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    dk_q <= '0;
                    dv_q <= '0;
                end else begin
                    dk_q <= dk_d;
                    dv_q <= dv_d;
                end
            end

            assign accumulator[c] = dk_q[D-1];
            assign unused_dv      = dv_q[D-1];
        end
    end

    // The bottom-right PE sees every vector last, aligned with the deskew.
    assign out_valid = vld_link[ROWS-1][COLS];

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int CW   = 4;
    localparam int AW   = 16;
    localparam int AW8  = 8;
    localparam int LAT  = ROWS + COLS - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, load_en, start, in_valid, in_last;
    logic [COLS-1:0][CW-1:0] weight_in;
    logic [ROWS-1:0][CW-1:0] in_vec;

    logic in_ready, out_valid, busy, done;
    logic [COLS-1:0][AW-1:0] acc;
    logic in_ready8, out_valid8, busy8, done8;
    logic [COLS-1:0][AW8-1:0] acc8;

    systolic_array #(
        .ROWS(ROWS), .COLS(COLS),
        .COMPUTE_DATA_WIDTH(CW), .ACCUMULATOR_DATA_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .weight_in(weight_in),
        .start(start), .in_valid(in_valid), .in_last(in_last), .in(in_vec),
        .in_ready(in_ready), .out_valid(out_valid), .accumulator(acc),
        .busy(busy), .done(done)
    );

    // Narrow-accumulator copy sharing the stimulus, for overflow behaviour.
    systolic_array #(
        .ROWS(ROWS), .COLS(COLS),
        .COMPUTE_DATA_WIDTH(CW), .ACCUMULATOR_DATA_WIDTH(AW8)
    ) dut8 (
        .clk(clk), .rst(rst), .load_en(load_en), .weight_in(weight_in),
        .start(start), .in_valid(in_valid), .in_last(in_last), .in(in_vec),
        .in_ready(in_ready8), .out_valid(out_valid8), .accumulator(acc8),
        .busy(busy8), .done(done8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic signed [AW-1:0]  q0[$], q1[$];
    logic signed [AW8-1:0] q80[$], q81[$];
    int                    qc[$], qd[$], qa[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q0.push_back($signed(acc[0]));
            q1.push_back($signed(acc[1]));
            q80.push_back($signed(acc8[0]));
            q81.push_back($signed(acc8[1]));
            qc.push_back(cyc);
            qd.push_back(int'(done));
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q80.delete(); q81.delete();
        qc.delete(); qd.delete(); qa.delete();
    endtask

    task automatic set_row(input int w0, input int w1);
        weight_in[0] = CW'(w0);
        weight_in[1] = CW'(w1);
    endtask

    task automatic load_w(input int w00, input int w01, input int w10, input int w11);
        load_en = 1'b1;
        set_row(w00, w01);
        tick();
        set_row(w10, w11);
        tick();
        load_en = 1'b0;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int a0, input int a1, input bit last);
        in_valid  = 1'b1;
        in_last   = last;
        in_vec[0] = CW'(a0);
        in_vec[1] = CW'(a1);
        tick();
        qa.push_back(cyc);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, longint'(done), 1);
        tick();
    endtask

    task automatic check_res(input string tag, input int idx, input int e0, input int e1,
                             input int edone);
        if (idx < q0.size()) begin
            chk({tag, "_c0"}, q0[idx], e0);
            chk({tag, "_c1"}, q1[idx], e1);
            chk({tag, "_lat"}, qc[idx], qa[idx] + LAT - 1);
            chk({tag, "_done"}, qd[idx], edone);
        end else begin
            chk({tag, "_missing"}, q0.size(), idx + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        weight_in = '0; in_vec = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_acc0", $signed(acc[0]), 0);
        chk("rst_acc1", $signed(acc[1]), 0);

        // Start before any weights are loaded is ignored
        start_pass();
        chk("start_noload_busy", busy, 0);

        // Start together with a load is ignored, the load still happens
        load_en = 1'b1; start = 1'b1; set_row(1, 2);
        tick();
        start = 1'b0;
        chk("start_with_load_busy", busy, 0);
        set_row(3, 4);
        tick();
        load_en = 1'b0;

        // Single vector, cycle-exact: W=[[1,2],[3,4]], in=[5,6] -> [23,34]
        clear_q();
        start_pass();
        chk("p1_busy", busy, 1);
        chk("p1_in_ready", in_ready, 1);
        send(5, 6, 1'b1);
        chk("p1_ready_drain", in_ready, 0);
        chk("p1_ovld_n1", out_valid, 0);
        tick();
        chk("p1_ovld_n2", out_valid, 0);
        chk("p1_done_n2", done, 0);
        tick();
        chk("p1_ovld_n3", out_valid, 1);
        chk("p1_done_n3", done, 1);
        chk("p1_acc0", $signed(acc[0]), 23);
        chk("p1_acc1", $signed(acc[1]), 34);
        tick();
        chk("p1_idle_busy", busy, 0);
        chk("p1_idle_ovld", out_valid, 0);
        chk("p1_idle_done", done, 0);
        tick(); tick();
        chk("p1_hold_acc0", $signed(acc[0]), 23);
        chk("p1_hold_acc1", $signed(acc[1]), 34);

        // Back-to-back vectors give back-to-back results
        clear_q();
        start_pass();
        send(1, 0, 1'b0);
        send(0, 1, 1'b0);
        send(2, 2, 1'b1);
        wait_done("b2b");
        chk("b2b_count", q0.size(), 3);
        check_res("b2b_r0", 0, 1, 2, 0);
        check_res("b2b_r1", 1, 3, 4, 0);
        check_res("b2b_r2", 2, 8, 12, 1);

        // Negative extremes; narrow copy overflows in column 0
        load_w(-8, 7, -8, 7);
        clear_q();
        start_pass();
        send(-8, -8, 1'b1);
        wait_done("neg");
        check_res("neg", 0, 128, -112, 1);
        if (q80.size() > 0) begin
`ifdef MAC_SATURATE_EN
            chk("acc8_ovf_c0", q80[0], 127);
`else
            chk("acc8_ovf_c0", q80[0], -128);
`endif
            chk("acc8_ovf_c1", q81[0], -112);
        end else begin
            chk("acc8_ovf_missing", q80.size(), 1);
        end

        // Second pass with new weights
        load_w(7, 7, 7, 7);
        clear_q();
        start_pass();
        send(7, 7, 1'b1);
        wait_done("pos");
        check_res("pos", 0, 98, 98, 1);
        if (q80.size() > 0) begin
            chk("acc8_pos_c0", q80[0], 98);
            chk("acc8_pos_c1", q81[0], 98);
        end else begin
            chk("acc8_pos_missing", q80.size(), 1);
        end

        // load_en during COMPUTE is ignored; the idle cycle is a bubble
        load_w(1, 2, 3, 4);
        clear_q();
        start_pass();
        load_en = 1'b1; set_row(7, 7);
        tick();
        load_en = 1'b0;
        send(5, 6, 1'b1);
        wait_done("ldc");
        chk("ldc_count", q0.size(), 1);
        check_res("ldc", 0, 23, 34, 1);

        // Row pointer must still be at row 0 after the ignored load
        load_w(2, 0, 0, 3);
        clear_q();
        start_pass();
        send(1, 2, 1'b1);
        wait_done("wptr");
        check_res("wptr", 0, 2, 6, 1);

        // Reset during DRAIN
        clear_q();
        start_pass();
        send(5, 6, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstd_ovld", out_valid, 0);
        chk("rstd_busy", busy, 0);
        chk("rstd_in_ready", in_ready, 0);
        chk("rstd_done", done, 0);
        chk("rstd_acc0", $signed(acc[0]), 0);
        chk("rstd_acc1", $signed(acc[1]), 0);
        tick(); tick(); tick(); tick();
        chk("rstd_no_result", q0.size(), 0);
        start_pass();
        chk("rstd_start_noload_busy", busy, 0);

        // Fresh load after reset works
        load_w(1, 2, 3, 4);
        clear_q();
        start_pass();
        send(5, 6, 1'b1);
        wait_done("fresh");
        check_res("fresh", 0, 23, 34, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
